// File: rtl/sha_blk_loader.sv
// sha_blk_loader: assembles a word-serial 32-bit message stream into 512-bit blocks
// for the SHA compression core. Word 0 of a block lands in blk[511:480].
// Optional feature: define SHA_LD_PINGPONG_EN for two fill buffers (ping-pong), so one
// buffer can fill while the other is presented. Undefined: a single buffer.
module sha_blk_loader (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_vld,
  input  logic [31:0]  din,
  input  logic         din_first,
  input  logic         blk_ack,
  input  logic         clr_ovf,
  output logic         blk_vld,
  output logic [511:0] blk,
  output logic         blk_init,
  output logic         ovf
);

`ifdef SHA_LD_PINGPONG_EN
  localparam logic PingPong = 1'b1;
`else
  localparam logic PingPong = 1'b0;
`endif

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} buf_st_e;

  // Pointers only toggle in ping-pong builds; single-buffer builds stay on buffer 0.
  buf_st_e          st_q   [2];
  buf_st_e          st_d   [2];
  logic             init_q [2];
  logic             init_d [2];
  logic [15:0][31:0] mem_q [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             binit_q, binit_d;
  logic             wr_en;
  logic             ack;
  logic [3:0]       slot;

  // Next-state: buffer states, fill counter, pointers, overflow and presented outputs.
  always_comb begin
    st_d    = st_q;
    init_d  = init_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ack     = vld_q & blk_ack;
    // The fill buffer is only FULL when every buffer is FULL, so this is the drop test.
    wr_en   = din_vld & (st_q[wr_q] != StFull);
    slot    = din_first ? 4'd0 : cnt_q;

    if (ack) begin
      st_d[rd_q] = StEmpty;
      rd_d       = rd_q ^ PingPong;
    end

    if (wr_en) begin
      // A restart via din_first simply rewrites slot 0 of the same buffer.
      if (slot == 4'd0) begin
        init_d[wr_q] = din_first;
      end
      cnt_d = slot + 4'd1;
      if (slot == 4'd15) begin
        st_d[wr_q] = StFull;
        wr_d       = wr_q ^ PingPong;
      end else begin
        st_d[wr_q] = StFilling;
      end
    end

    // Set wins over clear.
    ovf_d   = (din_vld & ~wr_en) | (ovf_q & ~clr_ovf);
    vld_d   = (st_d[rd_d] == StFull);
    binit_d = vld_d & init_d[rd_d];
  end

  // Control state and registered outputs; everything clears asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]   <= StEmpty;
      st_q[1]   <= StEmpty;
      init_q[0] <= 1'b0;
      init_q[1] <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 4'd0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      binit_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      init_q    <= init_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      binit_q   <= binit_d;
    end
  end

  // Block data storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q][4'd15 - slot] <= din;
    end
  end

  assign blk_vld  = vld_q;
  assign blk_init = binit_q;
  assign blk      = mem_q[rd_q];
  assign ovf      = ovf_q;

endmodule

// File: doc/sha_blk_loader.md
SHA_BLK_LOADER -- requirements
Module: sha_blk_loader

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL: din_vld  input  1  one 32-bit message word presented this cycle (word-serial stream from the double-SHA word generator or the host path).
REQ-004 SHALL: din  input  32  message word; the first word of a block is the most significant.
REQ-005 SHALL: din_first  input  1  qualifies din_vld; word is word 0 of a new message.
REQ-006 SHALL: blk_ack  input  1  compression core accepts the presented block.
REQ-007 SHALL: clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 SHALL: blk_vld  output  1  a complete 512-bit block is presented.
REQ-009 SHALL: blk  output  512  presented block; word k is at bits [511-32k : 480-32k].
REQ-010 SHALL: blk_init  output  1  the presented block starts a message (core loads IV, not the chaining value).
REQ-011 SHALL: ovf  output  1  sticky flag: a word was dropped.

Function
REQ-012 SHALL: a 4-bit fill counter selects the write slot; each accepted din_vld writes din to slot k = counter and increments the counter, wrapping 15 -> 0.
REQ-013 SHALL: din_vld with din_first forces the write to slot 0, discards any partial block in the fill buffer, and marks the block as init.
REQ-014 SHALL: a block without din_first at word 0 carries blk_init = 0 (chained block).
REQ-015 SHALL: the write of slot 15 marks the fill buffer full; blk_vld rises the cycle after the slot-15 word is sampled (latency 1).
REQ-016 SHALL: blk, blk_init stay stable while blk_vld = 1 until blk_ack is sampled high; blk_ack with blk_vld = 0 is ignored.
REQ-017 SHALL: buffer state per buffer: EMPTY -> FILLING (first word) -> FULL (slot 15) -> EMPTY (blk_ack while presented).
REQ-018 SHALL: buffers are presented in fill order; after blk_ack, if the other buffer is FULL, blk_vld stays 1 and blk switches to it the next cycle; otherwise blk_vld falls the next cycle.
REQ-019 SHALL: blk_ack in the same cycle as a slot-15 write: the acked buffer empties and the newly filled one is presented the next cycle with blk_vld held high.
REQ-020 SHALL: din_vld when no buffer is EMPTY or FILLING drops the word (counter unchanged) and sets ovf the next cycle.
REQ-021 SHALL: ovf stays 1 until clr_ovf is sampled high; overflow and clr_ovf in the same cycle leave ovf = 1.

Reset
REQ-022 SHALL: rst asserted clears fill counter, all buffer states to EMPTY, blk_vld = 0, blk_init = 0, ovf = 0 immediately, including mid-block and mid-presentation.
REQ-023 SHALL: blk data contents are don't-care after reset; blk is only meaningful while blk_vld = 1.

Configuration
REQ-024 SHALL: macro SHA_LD_PINGPONG_EN defined -> two 512-bit buffers, filling one while the other is FULL/presented.
REQ-025 SHALL: SHA_LD_PINGPONG_EN undefined -> one buffer; any din_vld while it is FULL is an overflow per REQ-020; all other behaviour unchanged.

Verification
REQ-026 SHALL: din_first + 16 words 0x00000000..0x0000000F, no ack -> next cycle blk_vld = 1, blk_init = 1, blk[511:480] = 0x00000000, blk[31:0] = 0x0000000F, held 10 cycles.
REQ-027 SHALL: 32 words, second block without din_first, ack each on first blk_vld cycle -> two blocks presented, blk_init 1 then 0, no ovf.
REQ-028 SHALL: (PINGPONG_EN) 48 back-to-back words, no ack -> ovf = 1 after word 33, words 33-48 dropped; ack twice -> blocks 1, 2 in order, then blk_vld = 0; undefined macro -> ovf after word 17.
REQ-029 SHALL: 5 words then din_first + 16 words 0xA5A5A5A5 -> presented block is all 0xA5A5A5A5, blk_init = 1.
REQ-030 SHALL: rst pulsed after word 9 and while a block is presented -> blk_vld = 0, ovf = 0, next din_first block assembles correctly.
